mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/mem_seq_if.sv | 37 +++
 rtl/mem_seq.sv | 135 +++++++++++++
 tb/tb_mem_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_if.sv
// +--------------------------------------------------------------------------+
// | mem_seq_if : request/response and memory-strobe bundle for mem_seq       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_cs;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [3:0]  err_cnt;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_cs, mem_we, mem_addr, mem_din, err_cnt
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_cs, mem_we, mem_addr, mem_din, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_seq.sv
// +--------------------------------------------------------------------------+
// | mem_seq  : single-request memory sequencer with falling-edge strobes     |
// | Option   : MEMSEQ_WRVERIFY_EN adds a one-cycle readback after writes     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_seq #(
  parameter int NROWS = 3
) (
  input  logic       clkp,
  input  logic       rstp,
  mem_seq_if.slave   bus
);

  localparam logic [3:0] c_NROWS = 4'(NROWS);

`ifdef MEMSEQ_WRVERIFY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_VERIFY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;
  logic        r_live;
  logic        r_we;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [3:0]  r_err_cnt;
  logic        r_mem_cs;
  logic        r_mem_we;
  logic [2:0]  r_mem_addr;
  logic [15:0] r_mem_din;
  logic        w_hs;
  logic        w_in_range;
  logic        w_consume;

  // r_live keeps req_ready low until the first rising edge after reset
  assign bus.req_ready = r_live & (r_state == S_IDLE);
  assign w_hs          = bus.req_valid & bus.req_ready;
  assign w_in_range    = ({1'b0, bus.req_addr} < c_NROWS);
  assign w_consume     = (r_state == S_RESP) & bus.rsp_ready;

  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_next = w_in_range ? S_ACCESS : S_RESP;
`ifdef MEMSEQ_WRVERIFY_EN
      S_ACCESS: w_next = r_we ? S_VERIFY : S_RESP;
      S_VERIFY: w_next = S_RESP;
`else
      S_ACCESS: w_next = S_RESP;
`endif
      S_RESP:   if (bus.rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clkp or posedge rstp) begin
    if (rstp) begin
      r_live    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 3'd0;
      r_wdata   <= 16'd0;
      r_rdata   <= 16'd0;
      r_err     <= 1'b0;
      r_err_cnt <= 4'd0;
    end else begin
      r_live <= 1'b1;
      if (w_hs) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_rdata <= 16'd0;
        r_err   <= ~w_in_range;
      end
      if (r_state == S_ACCESS && !r_we)
        r_rdata <= bus.mem_dout;
`ifdef MEMSEQ_WRVERIFY_EN
      if (r_state == S_VERIFY && bus.mem_dout != r_wdata)
        r_err <= 1'b1;
`endif
      if (w_consume && r_err && r_err_cnt != 4'hF)
        r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

  // Strobes launch on the falling edge so they are settled across the high phase
  always_ff @(negedge clkp or posedge rstp) begin
    if (rstp) begin
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= 3'd0;
      r_mem_din  <= 16'd0;
    end else begin
`ifdef MEMSEQ_WRVERIFY_EN
      r_mem_cs <= (r_state == S_ACCESS) || (r_state == S_VERIFY);
`else
      r_mem_cs <= (r_state == S_ACCESS);
`endif
      r_mem_we   <= (r_state == S_ACCESS) && r_we;
      r_mem_addr <= r_addr;
      r_mem_din  <= r_wdata;
    end
  end

  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.mem_cs    = r_mem_cs;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_mem_seq.sv
// +--------------------------------------------------------------------------+
// | tb_mem_seq : scoreboard bench for mem_seq with a behavioural row memory  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_seq;

`ifdef MEMSEQ_WRVERIFY_EN
  localparam int   c_WCYC = 4;
  localparam logic c_VERR = 1'b1;
`else
  localparam int   c_WCYC = 3;
  localparam logic c_VERR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clkp = 1'b0;
  logic rstp = 1'b1;
  always #5 clkp = ~clkp;

  mem_seq_if bus ();
  mem_seq #(.NROWS(3)) dut (.clkp(clkp), .rstp(rstp), .bus(bus));

  int          n_vec = 0;
  int          n_bad = 0;
  int          we_pulses = 0;
  int          cs_edges = 0;
  logic        inv_bad = 1'b0;
  logic        stuck0 = 1'b0;
  logic [15:0] mem_m [0:7] = '{default: 16'h0000};
  exp_t        sb [$];

  // Row memory: combinational read, write at the rising edge
  assign bus.mem_dout = (bus.mem_cs && !bus.mem_we) ?
                        (mem_m[bus.mem_addr] & (stuck0 ? 16'hFFFE : 16'hFFFF)) : 16'h0000;

  always @(posedge clkp) begin
    if (bus.mem_cs && bus.mem_we) begin
      mem_m[bus.mem_addr] <= bus.mem_din;
      we_pulses++;
    end
    if (bus.mem_cs) cs_edges++;
    if (bus.mem_we && !bus.mem_cs) inv_bad = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is consumed at the next rising edge when valid & ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clkp);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata %0h err %0b expected none", bus.rsp_rdata, bus.rsp_err);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          check("rsp_err",   32'(bus.rsp_err),   32'(e.err));
        end
      end
    end
  end

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(posedge clkp); #1;
      cyc++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] addr, input logic [15:0] wd,
                        input logic [15:0] erd, input logic eerr, output int cyc);
    int c;
    wait_ready(c);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    sb.push_back({erd, eerr});
    @(posedge clkp); #1;
    bus.req_valid = 1'b0;
    wait_ready(c);
    cyc = c + 1;
  endtask

  initial begin
    int cyc;
    int p;
    int k;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 3'd0;
    bus.req_wdata = 16'd0;
    bus.rsp_ready = 1'b1;

    @(posedge clkp); #1;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_err_cnt",   32'(bus.err_cnt),   0);
    check("rst_mem_cs",    32'(bus.mem_cs),    0);
    check("rst_mem_din",   32'(bus.mem_din),   0);
    rstp = 1'b0;
    check("ready_before_edge", 32'(bus.req_ready), 0);
    @(posedge clkp); #1;
    check("ready_after_edge", 32'(bus.req_ready), 1);

    // Write then read back row 1
    p = we_pulses;
    do_req(1'b1, 3'd1, 16'hA5C3, 16'h0000, 1'b0, cyc);
    check("write_cycles", 32'(cyc), 32'(c_WCYC));
    check("we_pulse_count", 32'(we_pulses - p), 1);
    do_req(1'b0, 3'd1, 16'h0000, 16'hA5C3, 1'b0, cyc);
    check("read_cycles", 32'(cyc), 3);

    // Out-of-range read: no strobe, error counted
    p = cs_edges;
    do_req(1'b0, 3'd5, 16'h0000, 16'h0000, 1'b1, cyc);
    check("oor_no_cs", 32'(cs_edges - p), 0);
    check("err_cnt_1", 32'(bus.err_cnt), 1);

    // Response held with rsp_ready low; request wiggles must be ignored
    do_req(1'b1, 3'd0, 16'h1234, 16'h0000, 1'b0, cyc);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 3'd0;
    sb.push_back({16'h1234, 1'b0});
    @(posedge clkp); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 10) begin
      @(posedge clkp); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      check("hold_rsp_rdata", 32'(bus.rsp_rdata), 32'h1234);
      check("hold_req_ready", 32'(bus.req_ready), 0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 3'(i);
      bus.req_wdata = 16'hDEAD;
      @(posedge clkp); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clkp); #1;
    check("release_idle", 32'(bus.req_ready), 1);
    check("release_rsp_valid", 32'(bus.rsp_valid), 0);

    // Write with bit 0 of the readback stuck low
    stuck0 = 1'b1;
    do_req(1'b1, 3'd3 - 3'd1, 16'hA5C3, 16'h0000, c_VERR, cyc);
    stuck0 = 1'b0;
    check("verify_cycles", 32'(cyc), 32'(c_WCYC));
    do_req(1'b0, 3'd2, 16'h0000, 16'hA5C3, 1'b0, cyc);
    do_req(1'b1, 3'd2, 16'h0000, 16'h0000, 1'b0, cyc);

    // Error counter saturation
    for (int i = 0; i < 17; i++)
      do_req(1'b0, 3'(4 + (i % 4)), 16'h0000, 16'h0000, 1'b1, cyc);
    check("err_cnt_sat", 32'(bus.err_cnt), 15);

    // Reset in the ACCESS cycle of a write to row 2
    wait_ready(cyc);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd2;
    bus.req_wdata = 16'hBEEF;
    @(posedge clkp); #1;
    bus.req_valid = 1'b0;
    @(negedge clkp); #1;
    check("abort_cs_active", 32'(bus.mem_cs), 1);
    check("abort_we_active", 32'(bus.mem_we), 1);
    p = we_pulses;
    rstp = 1'b1;
    #1;
    check("abort_cs_drop", 32'(bus.mem_cs), 0);
    check("abort_we_drop", 32'(bus.mem_we), 0);
    check("abort_err_cnt", 32'(bus.err_cnt), 0);
    @(posedge clkp); #1;
    check("abort_no_rsp", 32'(bus.rsp_valid), 0);
    check("abort_no_write", 32'(we_pulses - p), 0);
    rstp = 1'b0;
    @(posedge clkp); #1;
    check("abort_ready", 32'(bus.req_ready), 1);
    do_req(1'b0, 3'd2, 16'h0000, 16'h0000, 1'b0, cyc);

    @(posedge clkp); #1;
    check("we_without_cs", 32'(inv_bad), 0);
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
